// File: rtl/apb_global_pkg.sv
// Shared APB types and widths for the VIP and the in-house completer.
// Used by apb_slave_mem_responder and apb_slave_mem_array.
package apb_global_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;

  typedef enum logic {
    NO_ERROR = 1'b0,
    ERROR    = 1'b1
  } slave_error_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  typedef enum bit {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_mem_array.sv
// Byte-strobed flop register file with asynchronous read.
// Cleared to zero by preset_n.
module apb_slave_mem_array
  import apb_global_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH/8-1:0]       strb,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      for (int i = 0; i < WIDTH/8; i++) begin
        if (strb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/apb_slave_mem_responder.sv
// APB4 completer with a byte-strobed register file and fixed wait states.
// Option APB_SLAVE_PROT_CHECK_EN: non-secure access to upper half errors.
module apb_slave_mem_responder
  import apb_global_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int          MEM_DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          WAIT_STATES   = 0
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  input  logic [DATA_WIDTH/8-1:0]  pstrb,
  input  logic [2:0]               pprot,
  output logic                     pready,
  output logic [DATA_WIDTH-1:0]    prdata,
  output logic                     pslverr
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  localparam logic [ADDRESS_WIDTH:0] WIN =
    (ADDRESS_WIDTH+1)'(MEM_DEPTH * BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] BASE =
    BASE_ADDR[ADDRESS_WIDTH-1:0];
  localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK =
    ADDRESS_WIDTH'(BYTES - 1);

  apb_slave_state_e state, state_nx;

  logic [3:0]               wait_cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  tx_type_e                 dir_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [BYTES-1:0]         strb_q;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IDX_W-1:0]         idx;
  logic                     err;
  logic                     prot_err;
  logic                     setup;
  logic                     active;
  logic                     done;
  logic                     we;
  logic [DATA_WIDTH-1:0]    rdata;
  slave_error_e             resp;

  assign setup  = psel & ~penable;
  assign active = psel & penable;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (setup) state_nx = ACCESS;
      ACCESS: if (!active || wait_cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
      addr_q   <= '0;
      dir_q    <= READ;
      wdata_q  <= '0;
      strb_q   <= '0;
    end else if (state == IDLE && setup) begin
      wait_cnt <= 4'(WAIT_STATES);
      addr_q   <= paddr;
      dir_q    <= pwrite ? WRITE : READ;
      wdata_q  <= pwdata;
      strb_q   <= pstrb;
    end else if (state == ACCESS && active && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

`ifdef APB_SLAVE_PROT_CHECK_EN
  logic ns_q;
  logic prot_unused;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                  ns_q <= 1'b0;
    else if (state == IDLE && setup) ns_q <= pprot[1];
  end

  assign prot_unused = pprot[0] ^ pprot[2];
  assign prot_err    = ns_q & idx[IDX_W-1];
`else
  logic prot_unused;

  assign prot_unused = ^pprot;
  assign prot_err    = 1'b0;
`endif

  // Subtraction wraps, so addresses below the base land far out of range.
  assign offset = addr_q - BASE;
  assign idx    = offset[LANE_W +: IDX_W];
  assign err    = ({1'b0, offset} >= WIN)
                | (|(offset & LANE_MASK))
                | prot_err;

  always_comb begin
    pready  = 1'b0;
    done    = 1'b0;
    we      = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    resp    = err ? ERROR : NO_ERROR;
    if (state == ACCESS && wait_cnt == 4'd0) begin
      pready  = 1'b1;
      done    = active;
      we      = done && dir_q == WRITE && resp == NO_ERROR;
      pslverr = resp == ERROR;
      if (dir_q == READ && resp == NO_ERROR) prdata = rdata;
    end
  end

  apb_slave_mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_mem (
    .pclk     (pclk),
    .preset_n (preset_n),
    .we       (we),
    .idx      (idx),
    .wdata    (wdata_q),
    .strb     (strb_q),
    .rdata    (rdata)
  );

endmodule

// File: doc/apb_slave_mem_responder.md
Name: apb_slave_mem_responder

Overview:
Synthesizable APB4 completer that answers the VIP master agent's transfers.
- Holds a byte-strobed register file of MEM_DEPTH words.
- Programmable wait states, checked by address range and alignment.
- Sits as the DUT-side slave behind one pselx bit so the master agent can be closed-loop tested without external RTL.

Parameters:
- ADDRESS_WIDTH, 32, paddr width (max 32)
- DATA_WIDTH, 32, pwdata/prdata width; legal 8/16/32
- MEM_DEPTH, 16, number of DATA_WIDTH words; power of two
- BASE_ADDR, 32'h0000_0000, first byte address decoded; aligned to MEM_DEPTH*DATA_WIDTH/8
- WAIT_STATES, 0, pready-low access cycles inserted per transfer (0..15)

Ports:
- pclk, input, 1, APB clock, rising edge
- preset_n, input, 1, asynchronous active-low reset
- psel, input, 1, this slave's pselx bit
- penable, input, 1, access-phase indicator
- pwrite, input, 1, 1=WRITE, 0=READ
- paddr, input, ADDRESS_WIDTH, byte address
- pwdata, input, DATA_WIDTH, write data
- pstrb, input, DATA_WIDTH/8, write byte-lane strobes
- pprot, input, 3, protection attributes
- pready, output, 1, transfer completion
- prdata, output, DATA_WIDTH, read data
- pslverr, output, 1, transfer error (NO_ERROR/ERROR)

Behaviour:
- Interface: one clock pclk; reset preset_n is asynchronous and active-low.
- Reset values: state=IDLE, wait_cnt=0, all memory words=0, pready=0, prdata=0, pslverr=0.
- FSM states:
  - IDLE: on psel=1 & penable=0 (setup phase), latch paddr/pwrite/pwdata/pstrb/pprot, load wait_cnt=WAIT_STATES, go to ACCESS. If psel=0, or psel=1 & penable=1 with no prior setup (protocol violation), stay in IDLE and ignore.
  - ACCESS: while psel=1 & penable=1 & wait_cnt!=0, decrement wait_cnt.
    - pready = (state==ACCESS & wait_cnt==0). It is decoded from registers, never combinational from inputs.
    - The completion cycle is the one with pready=1. Next state is IDLE, so a back-to-back setup on the following cycle is accepted with no idle gap.
    - If psel=0 or penable=0 in ACCESS before completion (abort), go to IDLE, commit no write, and keep pready/pslverr at 0.
- Latency: setup cycle + (WAIT_STATES+1) access cycles. Minimum 2 cycles per transfer.
- Decode:
  - Offset = latched paddr - BASE_ADDR, computed modulo 2^ADDRESS_WIDTH.
  - Index = offset >> log2(DATA_WIDTH/8).
  - err = (offset >= MEM_DEPTH*DATA_WIDTH/8) | (offset[log2(DATA_WIDTH/8)-1:0] != 0).
- Write: committed at the rising edge that ends the completion cycle. Byte lane i is updated only if pstrb[i]=1. pstrb=0 is a legal no-op write with pslverr=0. If err, memory is unchanged.
- Read: prdata = mem[index] during the completion cycle, 0 otherwise. If err, prdata=0. pstrb is ignored on reads.
- pslverr = err during the completion cycle only, 0 otherwise.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. Any pending write is lost and memory clears.
- Address wrap: offsets above the window, including ones that wrap around from below BASE_ADDR, always fall in the error range.

Optional Feature:
- Macro: APB_SLAVE_PROT_CHECK_EN.
- Defined: an access with pprot[1]=1 (NON_SECURE) to the upper half of memory (index >= MEM_DEPTH/2) gives pslverr=1, no write, and prdata=0. pprot[0] and pprot[2] are ignored.
- Undefined: pprot is ignored entirely and the pprot port remains present.

Decomposition:
- apb_global_pkg: add typedef enum bit {IDLE, ACCESS} apb_slave_state_e. Reuse slave_error_e and tx_type_e from it, together with ADDRESS_WIDTH and DATA_WIDTH.
- Sub-module apb_slave_mem_array: MEM_DEPTH x DATA_WIDTH flop array with byte-enable write port (we, idx, wdata, strb) and asynchronous read (idx -> rdata), cleared by preset_n.

Test Plan:
- WAIT_STATES=0: write paddr=0x8, pwdata=0xDEADBEEF, pstrb=4'hF, then read 0x8 -> pready=1 in the first access cycle, prdata=0xDEADBEEF, pslverr=0.
- Partial strobe: after the above, write 0x8 with pwdata=0x11223344, pstrb=4'b0101, then read -> prdata=0xDE22BE44.
- WAIT_STATES=3: single read -> pready low for 3 access cycles and high on the 4th; transfer spans 5 cycles. A back-to-back second transfer starts its setup the cycle after completion.
- Errors: read 0x40 (out of range, MEM_DEPTH=16) and write 0x6 (misaligned) -> pslverr=1, prdata=0. A subsequent read of 0x4 returns its unchanged value.
- Abort: WAIT_STATES=2, write 0xC, drop psel in the 2nd access cycle -> no pready; a later read of 0xC returns the old value. Assert preset_n=0 mid-ACCESS -> pready=0 and prdata=0 immediately, and a later read of 0x8 returns 0.
- With APB_SLAVE_PROT_CHECK_EN: write 0x20 with pprot=3'b010 -> pslverr=1 and memory unchanged. The same write with pprot=3'b000 -> pslverr=0 and the write lands.
